// File: rtl/load_unit_if.sv
// Load unit bus bundle: pipeline load request, data-memory word read, writeback result.
interface load_unit_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_type;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_err;

    modport slave (
        input  ld_valid, ld_addr, ld_type, mem_gnt, mem_rvalid, mem_rdata, rd_ready,
        output ld_ready, mem_req, mem_addr, rd_valid, rd_data, rd_err
    );

    modport master (
        output ld_valid, ld_addr, ld_type, mem_gnt, mem_rvalid, mem_rdata, rd_ready,
        input  ld_ready, mem_req, mem_addr, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/load_unit.sv
// RV32 load unit: one outstanding word read, byte/half extraction, bus-error timeout.
// Optional LOAD_MISALIGN_CHECK_EN rejects misaligned LH/LHU/LW as illegal loads.
module load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         rst,
    load_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  type_q;
    logic [7:0]  cnt_q;
    logic [31:0] data_q;
    logic        err_q;
    logic        accept, bad_type, misalign, bad, timeout;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'd0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign accept   = bus.ld_valid && (state_q == IDLE);
    assign bad_type = (bus.ld_type == 3'd3) || (bus.ld_type == 3'd6) || (bus.ld_type == 3'd7);
`ifdef LOAD_MISALIGN_CHECK_EN
    assign misalign = (((bus.ld_type == 3'd1) || (bus.ld_type == 3'd5)) && bus.ld_addr[0]) ||
                      ((bus.ld_type == 3'd2) && (bus.ld_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign bad     = bad_type || misalign;
    assign timeout = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)                      state_d = bad ? RESP : REQ;
            REQ:  if (bus.mem_gnt)                 state_d = WAIT;
            WAIT: if (bus.mem_rvalid || timeout)   state_d = RESP;
            RESP: if (bus.rd_ready)                state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            type_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_q <= bus.ld_addr;
                    type_q <= bus.ld_type;
                    cnt_q  <= '0;
                    if (bad) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                REQ: cnt_q <= '0;
                WAIT: begin
                    // A response arriving on the final wait cycle beats the timeout.
                    if (bus.mem_rvalid) begin
                        data_q <= extract(bus.mem_rdata, addr_q[1:0], type_q);
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_ready = (state_q == IDLE);
    assign bus.mem_req  = (state_q == REQ);
    assign bus.mem_addr = {addr_q[31:2], 2'b00};
    assign bus.rd_valid = (state_q == RESP);
    assign bus.rd_data  = data_q;
    assign bus.rd_err   = err_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit (TIMEOUT_CYCLES=4); drives and samples on the falling edge.
module tb_load_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    load_unit_if bus();

    load_unit #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // rv_dly counts WAIT cycles after grant before rvalid; a large value means never.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                           input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                           input int rdy_dly, input logic [31:0] exp_data, input logic exp_err,
                           input logic [31:0] exp_maddr, input int exp_reqs, input int exp_lat);
        int reqs, lat, since, rdy_hi;
        logic granted;
        reqs = 0; lat = 0; since = 0; rdy_hi = 0; granted = 1'b0;
        chk({tag, " ld_ready idle"}, 32'(bus.ld_ready), 32'd1);
        bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_type = typ;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        while (!bus.rd_valid && lat < 300) begin
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            if (bus.ld_ready) rdy_hi++;
            if (bus.mem_req) begin
                chk({tag, " mem_addr"}, bus.mem_addr, exp_maddr);
                reqs++;
                if (reqs > gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    granted = 1'b1;
                end
            end else if (granted) begin
                if (since == rv_dly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                end
                since++;
            end
            lat++;
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, " req cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({tag, " ld_ready busy"}, 32'(rdy_hi), 32'd0);
        if (exp_lat >= 0) chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rd_data"}, bus.rd_data, exp_data);
        chk({tag, " rd_err"}, 32'(bus.rd_err), 32'(exp_err));
        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge clk);
            chk({tag, " hold rd_valid"}, 32'(bus.rd_valid), 32'd1);
            chk({tag, " hold rd_data"}, bus.rd_data, exp_data);
            chk({tag, " hold ld_ready"}, 32'(bus.ld_ready), 32'd0);
        end
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
        chk({tag, " done rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, " done ld_ready"}, 32'(bus.ld_ready), 32'd1);
    endtask

    initial begin
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_type = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst rd_data", bus.rd_data, 32'd0);
        chk("rst rd_err", 32'(bus.rd_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load("lb",  32'h1003, 3'd0, 32'h80FF_1234, 0, 0, 0, 32'hFFFF_FF80, 1'b0, 32'h1000, 1, 2);
        do_load("lbu", 32'h1003, 3'd4, 32'h80FF_1234, 0, 0, 0, 32'h0000_0080, 1'b0, 32'h1000, 1, 2);
        do_load("lb1", 32'h1001, 3'd0, 32'h80FF_1234, 0, 0, 0, 32'h0000_0012, 1'b0, 32'h1000, 1, 2);
        do_load("lh",  32'h2002, 3'd1, 32'h9ABC_0011, 0, 0, 0, 32'hFFFF_9ABC, 1'b0, 32'h2000, 1, 2);
        do_load("lhu", 32'h2002, 3'd5, 32'h9ABC_0011, 0, 0, 0, 32'h0000_9ABC, 1'b0, 32'h2000, 1, 2);
        do_load("lh0", 32'h2000, 3'd1, 32'h9ABC_8011, 0, 0, 0, 32'hFFFF_8011, 1'b0, 32'h2000, 1, 2);
        do_load("lw",  32'h0040, 3'd2, 32'hDEAD_BEEF, 3, 0, 2, 32'hDEAD_BEEF, 1'b0, 32'h0040, 4, 5);
        do_load("tmo", 32'h0100, 3'd2, 32'h1111_2222, 0, 1000, 1, 32'h0, 1'b1, 32'h0100, 1, 5);
        // Late response after the timeout has already been reported.
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("late rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("late ld_ready", 32'(bus.ld_ready), 32'd1);
        do_load("rv_last", 32'h0104, 3'd2, 32'hCAFE_F00D, 0, 3, 0, 32'hCAFE_F00D, 1'b0, 32'h0104, 1, 5);
`ifdef LOAD_MISALIGN_CHECK_EN
        do_load("mis_lw", 32'h0041, 3'd2, 32'h1234_5678, 0, 0, 0, 32'h0, 1'b1, 32'h0, 0, 0);
`else
        do_load("mis_lw", 32'h0041, 3'd2, 32'h1234_5678, 0, 0, 0, 32'h1234_5678, 1'b0, 32'h0040, 1, 2);
`endif
        do_load("ill3", 32'h0200, 3'd3, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1'b1, 32'h0, 0, 0);
        do_load("ill6", 32'h0200, 3'd6, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1'b1, 32'h0, 0, 0);
        do_load("ill7", 32'h0200, 3'd7, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1'b1, 32'h0, 0, 0);
        do_load("lw2", 32'h0080, 3'd2, 32'hA5A5_5A5A, 0, 0, 0, 32'hA5A5_5A5A, 1'b0, 32'h0080, 1, 2);

        // Reset while in WAIT, then a stray response.
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h0300; bus.ld_type = 3'd2;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("mid mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("mid mem_req0", 32'(bus.mem_req), 32'd0);
        chk("mid mem_addr", bus.mem_addr, 32'd0);
        chk("mid rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid rd_data", bus.rd_data, 32'd0);
        chk("mid rd_err", 32'(bus.rd_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("stray rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("stray rd_data", bus.rd_data, 32'd0);
        @(negedge clk);
        chk("stray ld_ready", 32'(bus.ld_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
